// File: rtl/hilo_seq_ctrl.sv
// Sequencer for the shared serial multu/divu HI/LO unit.
// Tracks occupancy and stalls ID-stage HI/LO users while busy.
module hilo_seq_ctrl #(
    parameter int DIV_STEPS = 32,
    parameter int MUL_STEPS = 32,
    parameter int CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        divisor_zero,
    output logic        op_start,
    output logic [1:0]  op_kind,
    output logic        step_en,
    output logic [4:0]  step_idx,
    output logic        hilo_we,
    output logic        busy,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        WRITE
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             dz_q;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       id_ok;
    logic       r_type;
    logic       is_div;
    logic       is_mul;
    logic       is_mf;
    logic       accept;
    logic       last;
    logic       unused_instr;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign id_ok  = id_valid && !flush;
    assign r_type = (opcode == 6'h00);
    assign is_div = id_ok && r_type && (funct == 6'h1b);
    assign is_mul = id_ok && r_type && (funct == 6'h19);
    assign is_mf  = id_ok && r_type &&
                    ((funct == 6'h10) || (funct == 6'h12));

    // Register fields are irrelevant to sequencing.
    assign unused_instr = ^instr[25:6];

    assign accept = (state == IDLE) && (is_div || is_mul);
    assign cnt_nx = cnt + CNT_W'(1);
    assign last   = op_kind[0] ? (cnt == MUL_LAST)
                               : (cnt == DIV_LAST);

    // HI/LO is unreadable until after the write edge, so WRITE stalls too.
    assign stall = (is_mf || is_div || is_mul) && (state != IDLE);

    // Sequencer FSM; outputs are registered for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dz_q     <= 1'b0;
            op_start <= 1'b0;
            op_kind  <= 2'b00;
            step_en  <= 1'b0;
            step_idx <= 5'd0;
            hilo_we  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= LOAD;
                        op_start <= 1'b1;
                        busy     <= 1'b1;
                        op_kind  <= is_mul ? 2'b01 : 2'b00;
                        dz_q     <= is_div && divisor_zero;
                    end
                end
                LOAD: begin
                    op_start <= 1'b0;
                    cnt      <= '0;
                    if (dz_q) begin
                        state   <= WRITE;
                        hilo_we <= 1'b1;
                    end else begin
                        state    <= RUN;
                        step_en  <= 1'b1;
                        step_idx <= 5'd0;
                    end
                end
                RUN: begin
                    if (last) begin
                        state    <= WRITE;
                        step_en  <= 1'b0;
                        step_idx <= 5'd0;
                        hilo_we  <= 1'b1;
                    end else begin
                        cnt      <= cnt_nx;
                        step_idx <= cnt_nx[4:0];
                    end
                end
                WRITE: begin
                    state   <= IDLE;
                    hilo_we <= 1'b0;
                    busy    <= 1'b0;
                    dz_q    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
